fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipeline. It tracks in-flight destination registers in a DEPTH-entry shift register, plus one multi-cycle (long-latency) unit with its own IDLE/BUSY/DONE state machine. From these it produces per-read-port forwarding selects and a single ID-stage stall. It sits beside the ID/EX boundary and replaces per-stage comparator logic with tracked state: producer readiness stage, WAW protection and long-op completion.

## Interface
- AW, 5: register index width (x0 is hard-wired zero).
- NPORT, 2: number of ID read ports checked.
- DEPTH, 3: tracked result stages; stage 0 = EX (youngest) … DEPTH-1 = WB.
- LONG_LAT, 4: long-unit latency in cycles, ≥1.
- Derived: STG_W = max(1, clog2(DEPTH)); SEL_W = clog2(DEPTH+2).
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- adv_i  in  1  pipeline advances this cycle.
- flush_i  in  1  squash the instruction currently in ID.
- issue_valid_i  in  1  ID holds a valid instruction.
- issue_we_i  in  1  the ID instruction writes rd.
- issue_rd_i  in  AW  destination register of the ID instruction.
- issue_rdy_stage_i  in  STG_W  first stage index at which the result is forwardable (ALU 0, load 1).
- issue_long_i  in  1  the ID instruction goes to the long unit.
- rs_en_i  in  NPORT  per-port read enable.
- rs_i  in  NPORT*AW  packed source registers; port p at [p*AW +: AW].
- fwd_sel_o  out  NPORT*SEL_W  packed selects: 0 = register file, k+1 = stage k, DEPTH+1 = long-unit result.
- stall_o  out  1  hold ID and insert a bubble into EX.
- long_busy_o  out  1  long unit is not in IDLE.
- long_wb_o  out  1  long result writes back this cycle.
- long_rd_o  out  AW  long-unit destination register.

## Operation
- Entry k holds {v, rd, rdy}. An instruction qualifies for tracking when issue_we_i=1 and issue_rd_i≠0; otherwise it is never tracked.
- On adv_i=1:
  - entry[k] <= entry[k-1] for k≥1.
  - entry[0] <= the ID instruction if issue_valid_i & qualified & ~issue_long_i & ~stall_o & ~flush_i; otherwise entry[0] becomes invalid (bubble).
- adv_i=0: all entries hold.
- Select for port p (combinational): rs_en=0 or rs=0 → 0. Otherwise the youngest valid k with rd==rs gives k+1. If no entry matches and state is DONE with long_rd==rs, the select is DEPTH+1. Otherwise 0.
- stall_o = issue_valid_i & ~flush_i & (any of the following):
  - an enabled port's youngest match has rdy > k;
  - no pipe match, state BUSY and long_rd==rs;
  - issue_long_i and state≠IDLE;
  - qualified issue with issue_rd_i==long_rd and state≠IDLE (WAW).
- Long FSM:
  - IDLE → BUSY on adv_i & issue_valid_i & issue_long_i & qualified & ~stall_o & ~flush_i. This transition latches long_rd and sets cnt = LONG_LAT-1.
  - BUSY: cnt decrements every cycle, independent of adv_i. When cnt==0, go to DONE.
  - DONE: hold until adv_i=1, then return to IDLE. long_wb_o = (state==DONE) & adv_i.
- flush_i never affects entries already tracked or a BUSY/DONE long op, since those are older than the ID instruction.

## Timing
- Selects and stall_o are combinational from state and inputs. State updates on the clk rising edge.
- Long op accepted at edge t0: BUSY is visible for LONG_LAT cycles, and DONE is visible from edge t0+LONG_LAT.
- Reset (asynchronous, any time, including mid-BUSY):
  - all entries invalid, state IDLE, cnt=0, long_rd=0;
  - fwd_sel_o=0, stall_o=0, long_busy_o=0, long_wb_o=0, long_rd_o=0.
- Simultaneous events:
  - stall_o and adv_i together → bubble enters entry 0.
  - DONE retiring while a new long op is in ID → that long op stalls for this cycle and is accepted on the next adv_i.

## Test plan
- ALU chain (DEPTH=3): issue x5 with rdy=0, adv each cycle, then rs_i[0]=5 → sel 1, 2, 3, 0 on consecutive cycles; stall_o=0 throughout.
- Load-use: issue x7 with rdy=1; next cycle rs=7 → stall_o=1 and sel=1. After one adv, x7 is in stage 1 → sel=2, stall_o=0.
- Priority and x0: x3 in stage 2 and stage 0 → sel=1. A tracked rd=0 instruction → never inserted, and rs=0 → sel 0. Port 1 with rs_en=0 → sel 0.
- Long op (LONG_LAT=4): long x9 accepted at t0; rs=9 → stall_o=1 for 4 cycles. At t0+4, DONE: sel=4, stall_o=0, long_wb_o=1 when adv_i=1. An ALU write to x9 issued during BUSY → stall_o=1.
- Freeze/flush: with adv_i=0 for 3 cycles, entries hold and selects are unchanged. flush_i with adv_i → bubble inserted and stall_o=0.
- Async reset asserted mid-BUSY (cnt=2) → all outputs 0 immediately. After release, rs=9 → sel 0 and no stall.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit for the ID/EX boundary.
// In-flight destination registers are tracked in a DEPTH-entry shift register
// (stage 0 = EX, youngest). A single long-latency unit runs its own
// IDLE/BUSY/DONE machine. From this state the block derives per-port forwarding
// selects and one ID-stage stall.
//
// Handshake: there is no valid/ready pair. The ID instruction is taken only on a
// cycle with adv_i=1, issue_valid_i=1, stall_o=0 and flush_i=0. stall_o=1 with
// adv_i=1 holds ID and moves a bubble into EX.
module fwd_scoreboard #(
    parameter int AW       = 5,
    parameter int NPORT    = 2,
    parameter int DEPTH    = 3,
    parameter int LONG_LAT = 4,
    localparam int STG_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SEL_W   = $clog2(DEPTH + 2),
    localparam int CNT_W   = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   adv_i,
    input  logic                   flush_i,
    input  logic                   issue_valid_i,
    input  logic                   issue_we_i,
    input  logic [AW-1:0]          issue_rd_i,
    input  logic [STG_W-1:0]       issue_rdy_stage_i,
    input  logic                   issue_long_i,
    input  logic [NPORT-1:0]       rs_en_i,
    input  logic [NPORT*AW-1:0]    rs_i,
    output logic [NPORT*SEL_W-1:0] fwd_sel_o,
    output logic                   stall_o,
    output logic                   long_busy_o,
    output logic                   long_wb_o,
    output logic [AW-1:0]          long_rd_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Tracked pipeline entries
    logic [DEPTH-1:0]            ent_v_q,   ent_v_d;
    logic [DEPTH-1:0][AW-1:0]    ent_rd_q,  ent_rd_d;
    logic [DEPTH-1:0][STG_W-1:0] ent_rdy_q, ent_rdy_d;

    // Long-unit state
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [AW-1:0]    long_rd_q, long_rd_d;

    logic                        qualified;
    logic                        stall;
    logic                        take_pipe;
    logic                        take_long;
    logic                        long_active;
    logic [NPORT-1:0][SEL_W-1:0] sel;
    logic [NPORT-1:0]            port_stall;

    // x0 writes and non-writing instructions are never tracked
    assign qualified   = issue_we_i & (issue_rd_i != '0);
    assign long_active = (state_q != ST_IDLE);

    // Per-port select and RAW stall; descending scan so the youngest match wins
    always_comb begin
        sel        = '0;
        port_stall = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (rs_en_i[p] && (rs_i[p*AW +: AW] != '0)) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (ent_v_q[k] && (ent_rd_q[k] == rs_i[p*AW +: AW])) begin
                        sel[p]        = SEL_W'(k + 1);
                        port_stall[p] = (int'(ent_rdy_q[k]) > k);
                    end
                end
                // Long unit is only consulted when no pipe entry matched
                if ((sel[p] == '0) && (long_rd_q == rs_i[p*AW +: AW])) begin
                    if (state_q == ST_DONE) begin
                        sel[p] = SEL_W'(DEPTH + 1);
                    end
                    if (state_q == ST_BUSY) begin
                        port_stall[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Stall: RAW not yet forwardable, long unit occupied, or WAW against long op
    assign stall = issue_valid_i & ~flush_i &
                   ((|port_stall) |
                    (issue_long_i & long_active) |
                    (qualified & (issue_rd_i == long_rd_q) & long_active));

    assign take_pipe = adv_i & issue_valid_i & qualified & ~issue_long_i & ~stall & ~flush_i;
    assign take_long = adv_i & issue_valid_i & qualified &  issue_long_i & ~stall & ~flush_i;

    // Shift the tracked entries on advance; insert the ID instruction or a bubble
    always_comb begin
        ent_v_d   = ent_v_q;
        ent_rd_d  = ent_rd_q;
        ent_rdy_d = ent_rdy_q;
        if (adv_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                ent_v_d[k]   = ent_v_q[k-1];
                ent_rd_d[k]  = ent_rd_q[k-1];
                ent_rdy_d[k] = ent_rdy_q[k-1];
            end
            ent_v_d[0]   = take_pipe;
            ent_rd_d[0]  = take_pipe ? issue_rd_i : '0;
            ent_rdy_d[0] = take_pipe ? issue_rdy_stage_i : '0;
        end
    end

    // Long-unit FSM: BUSY counts down regardless of adv_i, DONE waits for adv_i
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        long_rd_d = long_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (take_long) begin
                    state_d   = ST_BUSY;
                    cnt_d     = CNT_W'(LONG_LAT - 1);
                    long_rd_d = issue_rd_i;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (adv_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_v_q   <= '0;
            ent_rd_q  <= '0;
            ent_rdy_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            long_rd_q <= '0;
        end else begin
            ent_v_q   <= ent_v_d;
            ent_rd_q  <= ent_rd_d;
            ent_rdy_q <= ent_rdy_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            long_rd_q <= long_rd_d;
        end
    end

    assign fwd_sel_o   = sel;
    assign stall_o     = stall;
    assign long_busy_o = long_active;
    assign long_wb_o   = (state_q == ST_DONE) & adv_i;
    assign long_rd_o   = long_rd_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (AW=5, NPORT=2, DEPTH=3, LONG_LAT=4).
module tb_fwd_scoreboard;

    localparam int AW    = 5;
    localparam int NPORT = 2;
    localparam int DEPTH = 3;
    localparam int SEL_W = 3;
    localparam int STG_W = 2;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   adv_i;
    logic                   flush_i;
    logic                   issue_valid_i;
    logic                   issue_we_i;
    logic [AW-1:0]          issue_rd_i;
    logic [STG_W-1:0]       issue_rdy_stage_i;
    logic                   issue_long_i;
    logic [NPORT-1:0]       rs_en_i;
    logic [NPORT*AW-1:0]    rs_i;
    logic [NPORT*SEL_W-1:0] fwd_sel_o;
    logic                   stall_o;
    logic                   long_busy_o;
    logic                   long_wb_o;
    logic [AW-1:0]          long_rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_scoreboard #(.AW(AW), .NPORT(NPORT), .DEPTH(DEPTH), .LONG_LAT(4)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .adv_i             (adv_i),
        .flush_i           (flush_i),
        .issue_valid_i     (issue_valid_i),
        .issue_we_i        (issue_we_i),
        .issue_rd_i        (issue_rd_i),
        .issue_rdy_stage_i (issue_rdy_stage_i),
        .issue_long_i      (issue_long_i),
        .rs_en_i           (rs_en_i),
        .rs_i              (rs_i),
        .fwd_sel_o         (fwd_sel_o),
        .stall_o           (stall_o),
        .long_busy_o       (long_busy_o),
        .long_wb_o         (long_wb_o),
        .long_rd_o         (long_rd_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] sel(input int p);
        return 32'(fwd_sel_o[p*SEL_W +: SEL_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        adv_i             = 1'b1;
        flush_i           = 1'b0;
        issue_valid_i     = 1'b0;
        issue_we_i        = 1'b0;
        issue_rd_i        = '0;
        issue_rdy_stage_i = '0;
        issue_long_i      = 1'b0;
        rs_en_i           = '0;
        rs_i              = '0;
    endtask

    task automatic set_issue(input logic [AW-1:0] rd, input logic [STG_W-1:0] rdy, input logic lng);
        issue_valid_i     = 1'b1;
        issue_we_i        = 1'b1;
        issue_rd_i        = rd;
        issue_rdy_stage_i = rdy;
        issue_long_i      = lng;
    endtask

    // Valid ID instruction that writes nothing (pure consumer)
    task automatic set_consumer();
        issue_valid_i     = 1'b1;
        issue_we_i        = 1'b0;
        issue_rd_i        = '0;
        issue_rdy_stage_i = '0;
        issue_long_i      = 1'b0;
    endtask

    task automatic set_use(input int p, input logic en, input logic [AW-1:0] r);
        rs_en_i[p]       = en;
        rs_i[p*AW +: AW] = r;
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    initial begin
        // ---------------- reset ----------------
        set_idle();
        rstn = 1'b0;
        set_use(0, 1'b1, 5'd5);
        set_use(1, 1'b1, 5'd5);
        tick();
        tick();
        chk("rst_sel0", sel(0), 0);
        chk("rst_sel1", sel(1), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_busy", 32'(long_busy_o), 0);
        chk("rst_wb", 32'(long_wb_o), 0);
        chk("rst_long_rd", 32'(long_rd_o), 0);
        rstn = 1'b1;
        tick();

        // ---------------- ALU chain ----------------
        set_idle();
        set_issue(5'd5, 2'd0, 1'b0);
        set_use(0, 1'b1, 5'd5);
        settle();
        chk("alu_pre_sel", sel(0), 0);
        chk("alu_pre_stall", 32'(stall_o), 0);
        tick();
        set_consumer();
        settle();
        chk("alu_sel_k0", sel(0), 1);
        chk("alu_stall_k0", 32'(stall_o), 0);
        tick();
        chk("alu_sel_k1", sel(0), 2);
        chk("alu_stall_k1", 32'(stall_o), 0);
        tick();
        chk("alu_sel_k2", sel(0), 3);
        chk("alu_stall_k2", 32'(stall_o), 0);
        tick();
        chk("alu_sel_gone", sel(0), 0);
        chk("alu_stall_gone", 32'(stall_o), 0);
        drain();

        // ---------------- load-use ----------------
        set_idle();
        set_issue(5'd7, 2'd1, 1'b0);
        tick();
        set_consumer();
        set_use(0, 1'b1, 5'd7);
        settle();
        chk("ld_stall", 32'(stall_o), 1);
        chk("ld_sel_k0", sel(0), 1);
        tick();
        chk("ld_sel_k1", sel(0), 2);
        chk("ld_stall_k1", 32'(stall_o), 0);
        drain();

        // ---------------- priority and x0 ----------------
        set_idle();
        set_issue(5'd3, 2'd0, 1'b0);
        tick();
        set_idle();
        tick();
        set_issue(5'd3, 2'd0, 1'b0);
        tick();
        // x3 now in stage 2 and stage 0
        set_idle();
        set_use(0, 1'b1, 5'd3);
        set_use(1, 1'b0, 5'd3);
        settle();
        chk("pri_youngest", sel(0), 1);
        chk("pri_port1_disabled", sel(1), 0);
        set_use(1, 1'b1, 5'd0);
        settle();
        chk("pri_port1_x0", sel(1), 0);
        set_use(1, 1'b1, 5'd3);
        settle();
        chk("pri_port1_en", sel(1), 1);
        // non-writing instruction naming rd=3 must not be tracked
        set_consumer();
        issue_rd_i = 5'd3;
        tick();
        chk("pri_no_we_not_tracked", sel(0), 2);
        // rd=0 writer is not tracked either
        set_issue(5'd0, 2'd0, 1'b0);
        tick();
        chk("pri_x0_not_shadowing", sel(0), 3);
        set_use(0, 1'b1, 5'd0);
        settle();
        chk("pri_rs_x0", sel(0), 0);
        drain();

        // ---------------- freeze / flush ----------------
        set_idle();
        set_issue(5'd4, 2'd0, 1'b0);
        tick();
        set_issue(5'd6, 2'd1, 1'b0);
        tick();
        // e0 = x6 (rdy 1), e1 = x4; ID holds x8 reading x6 -> load-use stall
        set_issue(5'd8, 2'd0, 1'b0);
        adv_i = 1'b0;
        set_use(0, 1'b1, 5'd6);
        set_use(1, 1'b1, 5'd4);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("frz_sel0", sel(0), 1);
            chk("frz_sel1", sel(1), 2);
            chk("frz_stall", 32'(stall_o), 1);
            tick();
        end
        adv_i   = 1'b1;
        flush_i = 1'b1;
        settle();
        chk("flush_stall", 32'(stall_o), 0);
        tick();
        set_idle();
        set_use(0, 1'b1, 5'd8);
        set_use(1, 1'b1, 5'd6);
        settle();
        chk("flush_not_inserted", sel(0), 0);
        chk("flush_shifted", sel(1), 2);
        drain();

        // ---------------- long op ----------------
        set_idle();
        set_issue(5'd9, 2'd0, 1'b1);
        settle();
        chk("lng_pre_stall", 32'(stall_o), 0);
        chk("lng_pre_busy", 32'(long_busy_o), 0);
        tick();  // accepted at t0
        set_consumer();
        set_use(0, 1'b1, 5'd9);
        settle();
        chk("lng_busy_t0", 32'(long_busy_o), 1);
        chk("lng_stall_t0", 32'(stall_o), 1);
        chk("lng_sel_busy", sel(0), 0);
        tick();
        chk("lng_stall_t1", 32'(stall_o), 1);
        set_issue(5'd9, 2'd0, 1'b0);
        rs_en_i = '0;
        settle();
        chk("lng_waw_stall", 32'(stall_o), 1);
        set_consumer();
        set_use(0, 1'b1, 5'd9);
        tick();
        chk("lng_stall_t2", 32'(stall_o), 1);
        chk("lng_rd", 32'(long_rd_o), 9);
        tick();
        chk("lng_stall_t3", 32'(stall_o), 1);
        chk("lng_busy_t3", 32'(long_busy_o), 1);
        adv_i = 1'b0;
        tick();  // t0+4: DONE
        chk("lng_done_sel", sel(0), 4);
        chk("lng_done_stall", 32'(stall_o), 0);
        chk("lng_done_busy", 32'(long_busy_o), 1);
        chk("lng_done_wb_noadv", 32'(long_wb_o), 0);
        tick();  // DONE holds without adv
        chk("lng_done_hold_sel", sel(0), 4);
        adv_i = 1'b1;
        settle();
        chk("lng_wb", 32'(long_wb_o), 1);
        set_issue(5'd10, 2'd0, 1'b1);
        settle();
        chk("lng_retire_new_stall", 32'(stall_o), 1);
        chk("lng_retire_wb", 32'(long_wb_o), 1);
        tick();  // back to IDLE
        chk("lng_idle_busy", 32'(long_busy_o), 0);
        chk("lng_idle_wb", 32'(long_wb_o), 0);
        chk("lng_idle_stall", 32'(stall_o), 0);
        chk("lng_idle_sel", sel(0), 0);
        tick();  // x10 accepted, cnt=3
        chk("lng2_busy", 32'(long_busy_o), 1);
        chk("lng2_rd", 32'(long_rd_o), 10);
        set_consumer();
        set_use(0, 1'b1, 5'd10);
        tick();  // cnt=2
        chk("lng2_stall", 32'(stall_o), 1);

        // ---------------- async reset mid-BUSY ----------------
        rstn = 1'b0;
        settle();
        chk("arst_stall", 32'(stall_o), 0);
        chk("arst_busy", 32'(long_busy_o), 0);
        chk("arst_wb", 32'(long_wb_o), 0);
        chk("arst_long_rd", 32'(long_rd_o), 0);
        chk("arst_sel0", sel(0), 0);
        settle();
        rstn = 1'b1;
        set_use(0, 1'b1, 5'd9);
        settle();
        chk("arst_rel_sel", sel(0), 0);
        chk("arst_rel_stall", 32'(stall_o), 0);
        tick();
        chk("arst_rel_busy", 32'(long_busy_o), 0);
        chk("arst_rel_sel2", sel(0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
